// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/multiplexer2x1.sv
// Generic 2:1 multiplexer used on the memory address path (sel=1 picks b).
module multiplexer2x1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer sharing one memory port between
// instruction fetch and load/store; every output is driven from a register.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = cnt_width(LAT);

    state_t            state, state_nx;
    logic              owner, owner_nx;
    logic              last_owner, last_owner_nx;
    logic              is_store, is_store_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;

    logic              if_gnt_nx, ls_gnt_nx, if_rvalid_nx, ls_rvalid_nx;
    logic              mem_en_nx, mem_we_nx, mem_sel_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx, rdata_nx;

    logic              win_valid;
    logic              winner;
    logic [ADDR_W-1:0] mux_addr;

    // On a tie the requester that did not own the previous access wins.
    assign win_valid = if_req | ls_req;
    assign winner    = (if_req && ls_req) ? ~last_owner : (ls_req ? OWN_LS : OWN_IF);

    multiplexer2x1 #(.WIDTH(ADDR_W)) u_addr_mux (
        .a   (if_addr),
        .b   (ls_addr),
        .sel (winner),
        .y   (mux_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (win_valid) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Computes next values of the registered outputs; strobes default low.
    always_comb begin
        if_gnt_nx     = 1'b0;
        ls_gnt_nx     = 1'b0;
        if_rvalid_nx  = 1'b0;
        ls_rvalid_nx  = 1'b0;
        mem_en_nx     = 1'b0;
        mem_we_nx     = 1'b0;
        mem_sel_nx    = mem_sel;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        rdata_nx      = rdata;
        cnt_nx        = cnt;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        is_store_nx   = is_store;
        unique case (state)
            IDLE: begin
                if (win_valid) begin
                    owner_nx     = winner;
                    is_store_nx  = (winner == OWN_LS) && ls_we;
                    if_gnt_nx    = (winner == OWN_IF);
                    ls_gnt_nx    = (winner == OWN_LS);
                    mem_en_nx    = 1'b1;
                    mem_we_nx    = (winner == OWN_LS) && ls_we;
                    mem_sel_nx   = winner;
                    mem_addr_nx  = mux_addr;
                    mem_wdata_nx = ls_wdata;
                end
            end
            ISSUE: begin
                cnt_nx        = CNT_W'(LAT);
                last_owner_nx = owner;
            end
            WAIT: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    if (!is_store) rdata_nx = mem_rdata;
                    if_rvalid_nx = (owner == OWN_IF);
                    ls_rvalid_nx = (owner == OWN_LS);
                end
            end
            RESP: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_gnt     <= 1'b0;
            ls_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            ls_rvalid  <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_sel    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            cnt        <= '0;
            owner      <= OWN_IF;
            last_owner <= OWN_LS;
            is_store   <= 1'b0;
        end else begin
            if_gnt     <= if_gnt_nx;
            ls_gnt     <= ls_gnt_nx;
            if_rvalid  <= if_rvalid_nx;
            ls_rvalid  <= ls_rvalid_nx;
            mem_en     <= mem_en_nx;
            mem_we     <= mem_we_nx;
            mem_sel    <= mem_sel_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            rdata      <= rdata_nx;
            cnt        <= cnt_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            is_store   <= is_store_nx;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level schedule model (LAT=1), and a LAT=3 latency check.
module tb_mem_port_arbiter;

    localparam int NC   = 4096;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req, if_gnt, if_rvalid, ls_req, ls_we, ls_gnt, ls_rvalid;
    logic        mem_sel, mem_en, mem_we;
    logic [31:0] if_addr, ls_addr, ls_wdata, rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if_req3, if_gnt3, if_rvalid3, ls_req3, ls_we3, ls_gnt3, ls_rvalid3;
    logic        mem_sel3, mem_en3, mem_we3;
    logic [31:0] if_addr3, ls_addr3, ls_wdata3, rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .rdata(rdata),
        .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3),
        .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
        .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .rdata(rdata3),
        .mem_sel(mem_sel3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    // Expected per-cycle behaviour, filled in when the model grants a request.
    bit          exp_ifg [NC], exp_lsg [NC], exp_ifv [NC], exp_lsv [NC];
    bit          exp_en [NC], exp_we [NC], exp_sel [NC], exp_lswin [NC];
    logic [31:0] exp_addr [NC], exp_wd [NC], hist [NC], hist3 [NC];
    int          rd_src [NC];

    int          cyc, free_at, n_cmp, n_err;
    bit          last_own;
    logic [31:0] model_rd;
    bit          fixed_en;
    logic [31:0] fixed_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Arbitration decision for cycle c, using the requests present at its closing edge.
    task automatic model_arb(input int c);
        bit w;
        if (!rst && c >= 0 && c >= free_at && (if_req || ls_req)) begin
            w = (if_req && ls_req) ? !last_own : ls_req;
            last_own = w;
            exp_ifg[c+1]   = !w;
            exp_lsg[c+1]   = w;
            exp_en[c+1]    = 1'b1;
            exp_we[c+1]    = w && ls_we;
            exp_lswin[c+1] = w;
            exp_wd[c+1]    = ls_wdata;
            for (int i = c + 1; i < NC; i++) begin
                exp_sel[i]  = w;
                exp_addr[i] = w ? ls_addr : if_addr;
            end
            if (w) exp_lsv[c+2+LAT1] = 1'b1;
            else   exp_ifv[c+2+LAT1] = 1'b1;
            rd_src[c+2+LAT1] = (w && ls_we) ? -1 : c + 1 + LAT1;
            free_at = c + 3 + LAT1;
        end
    endtask

    task automatic model_reset(input int c);
        for (int i = c; i < NC; i++) begin
            exp_ifg[i] = 0; exp_lsg[i] = 0; exp_ifv[i] = 0; exp_lsv[i] = 0;
            exp_en[i] = 0; exp_we[i] = 0; exp_sel[i] = 0; exp_lswin[i] = 0;
            exp_addr[i] = '0;
        end
        last_own = 1'b1;
        model_rd = '0;
        free_at  = NC;
    endtask

    task automatic check_cycle(input int c);
        logic [31:0] erd;
        chk("if_gnt", if_gnt, exp_ifg[c]);
        chk("ls_gnt", ls_gnt, exp_lsg[c]);
        chk("if_rvalid", if_rvalid, exp_ifv[c]);
        chk("ls_rvalid", ls_rvalid, exp_lsv[c]);
        chk("mem_en", mem_en, exp_en[c]);
        chk("mem_we", mem_we, exp_en[c] & exp_we[c]);
        chk("mem_sel", mem_sel, exp_sel[c]);
        chk("mem_addr", mem_addr, exp_addr[c]);
        if (exp_lswin[c]) chk("mem_wdata", mem_wdata, exp_wd[c]);
        if (exp_ifv[c] || exp_lsv[c]) begin
            erd = (rd_src[c] >= 0) ? hist[rd_src[c]] : model_rd;
            model_rd = erd;
            chk("rdata", rdata, erd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_arb(cyc);
        #1;
        cyc++;
        check_cycle(cyc);
        mem_rdata  = fixed_en ? fixed_val : $urandom;
        hist[cyc]  = mem_rdata;
        mem_rdata3 = $urandom;
        hist3[cyc] = mem_rdata3;
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic lsr,
                         input logic lswe, input logic [31:0] lsa, input logic [31:0] lswd);
        if_req = ifr; if_addr = ifa; ls_req = lsr; ls_we = lswe; ls_addr = lsa; ls_wdata = lswd;
    endtask

    initial begin
        int  gcount, lastg, c0;
        bit  exp_next, ia, la, lwe;
        logic [31:0] iaddr, laddr, lwd;

        n_cmp = 0; n_err = 0; cyc = -1; free_at = 0; last_own = 1'b1;
        model_rd = '0; fixed_en = 0; fixed_val = '0;
        drive(0, '0, 0, 0, '0, '0);
        mem_rdata = '0; mem_rdata3 = '0;
        if_req3 = 0; if_addr3 = '0; ls_req3 = 0; ls_we3 = 0; ls_addr3 = '0; ls_wdata3 = '0;
        model_reset(0);
        repeat (2) @(posedge clk);

        // Reset state
        tick();
        chk("rst_rdata", rdata, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst3_outs", {if_gnt3, ls_gnt3, if_rvalid3, ls_rvalid3, mem_en3, mem_we3, mem_sel3}, 0);
        chk("rst3_data", {mem_addr3, mem_wdata3}, 0);
        chk("rst3_rdata", rdata3, 0);
        rst = 0; free_at = cyc;

        // Single fetch
        fixed_en = 1; fixed_val = 32'hAAAA_AAAA;
        drive(1, 32'h40, 0, 0, '0, '0);
        tick();
        chk("t1_gnt", if_gnt, 1); chk("t1_sel", mem_sel, 0); chk("t1_addr", mem_addr, 32'h40);
        drive(0, 32'h40, 0, 0, '0, '0);
        tick(); tick();
        chk("t1_rvalid", if_rvalid, 1); chk("t1_rdata", rdata, 32'hAAAA_AAAA);
        fixed_en = 0;
        tick();

        // Single store
        drive(0, '0, 1, 1, 32'h1000, 32'hBBBB_BBBB);
        tick();
        chk("t2_en", mem_en, 1); chk("t2_we", mem_we, 1); chk("t2_sel", mem_sel, 1);
        chk("t2_addr", mem_addr, 32'h1000); chk("t2_wdata", mem_wdata, 32'hBBBB_BBBB);
        drive(0, '0, 0, 0, 32'h1000, 32'hBBBB_BBBB);
        tick();
        chk("t2_en_off", mem_en, 0); chk("t2_we_off", mem_we, 0);
        tick();
        chk("t2_lsv", ls_rvalid, 1); chk("t2_ifv", if_rvalid, 0);
        tick();

        // Both held: alternating grants LAT+3 apart, IF first
        gcount = 0; lastg = 0; exp_next = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1, 32'h100, 1, 0, 32'h200, 32'h0);
            tick();
            chk("t3_excl", if_gnt & ls_gnt, 0);
            if (if_gnt || ls_gnt) begin
                chk("t3_order", ls_gnt, exp_next);
                if (gcount > 0) chk("t3_gap", cyc - lastg, LAT1 + 3);
                exp_next = !exp_next; lastg = cyc; gcount++;
            end
        end
        chk("t3_count", gcount, 4);
        drive(0, '0, 0, 0, '0, '0);
        repeat (4) tick();

        // LS raised during IF WAIT waits for the next IDLE
        drive(1, 32'h300, 0, 0, '0, '0);
        tick(); drive(0, 32'h300, 0, 0, '0, '0);
        tick(); drive(0, 32'h300, 1, 0, 32'h400, '0);
        tick(); chk("t4_resp_gnt", ls_gnt, 0);
        tick(); chk("t4_idle_gnt", ls_gnt, 0);
        tick(); chk("t4_gnt", ls_gnt, 1);
        drive(0, '0, 0, 0, 32'h400, '0);
        repeat (4) tick();

        // Reset during WAIT of a load
        drive(0, '0, 1, 0, 32'h500, '0);
        tick(); drive(0, '0, 0, 0, 32'h500, '0);
        tick();
        rst = 1; model_reset(cyc);
        #1;
        chk("t5_strobes", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, mem_sel}, 0);
        chk("t5_addr", mem_addr, 0); chk("t5_wdata", mem_wdata, 0); chk("t5_rdata", rdata, 0);
        tick();
        rst = 0; free_at = cyc;
        drive(1, 32'h600, 1, 0, 32'h700, '0);
        tick();
        chk("t5_tie_if", if_gnt, 1); chk("t5_tie_ls", ls_gnt, 0);
        drive(0, '0, 0, 0, '0, '0);
        repeat (5) tick();

        // Random traffic with occasional withdrawals
        ia = 0; la = 0; lwe = 0; iaddr = '0; laddr = '0; lwd = '0;
        repeat (1500) begin
            tick();
            if (if_gnt) ia = 0;
            if (ls_gnt) la = 0;
            if (!ia && $urandom_range(3) == 0) begin ia = 1; iaddr = $urandom; end
            else if (ia && $urandom_range(40) == 0) ia = 0;
            if (!la && $urandom_range(3) == 0) begin
                la = 1; laddr = $urandom; lwd = $urandom; lwe = 1'($urandom_range(1));
            end
            else if (la && $urandom_range(40) == 0) la = 0;
            drive(ia, iaddr, la, lwe, laddr, lwd);
        end
        drive(0, '0, 0, 0, '0, '0);
        repeat (6) tick();

        // LAT=3 single load
        c0 = cyc;
        ls_req3 = 1; ls_we3 = 0; ls_addr3 = 32'h2000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                chk("l3_gnt", ls_gnt3, 1); chk("l3_addr", mem_addr3, 32'h2000);
                chk("l3_sel", mem_sel3, 1); chk("l3_en", mem_en3, 1);
                ls_req3 = 0;
            end
            chk("l3_lsv", ls_rvalid3, (k == 5));
            chk("l3_ifv", if_rvalid3, 0);
            if (k == 5) chk("l3_rdata", rdata3, hist3[c0+4]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
